// File: rtl/uart_pkg.sv
// Shared UART receive definitions.
// Holds the receiver state encoding and oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is configurable so an idle-high line powers up idle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with optional parity.
// Holds the received word until the consumer accepts it.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int              BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD_C    = (PARITY_ODD != 0);
    localparam logic             PAR_C    = (PARITY_EN != 0);

    logic rx_sync;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 done;
    logic                 stop_bad;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 ovr_q, ovr_d;
    logic                 load;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_sync)
    );

    // Frame FSM and bit assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic; everything advances only on a 16x tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        done     = 1'b0;
        stop_bad = 1'b0;
        if (tick_16x) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_sync) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        if (rx_sync) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = PAR_C ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        perr_d  = (^shift_q) ^ rx_sync ^ ODD_C;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        done     = 1'b1;
                        stop_bad = !rx_sync;
                        state_d  = rx_sync ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output holding register and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
        end
    end

    // A completed frame loads only if the holding slot is free or draining.
    always_comb begin
        load    = done && (!valid_q || rx_ready);
        data_d  = load ? shift_q : data_q;
        fe_d    = load ? stop_bad : fe_q;
        pe_d    = load ? (perr_q & PAR_C) : pe_q;
        valid_d = load || (valid_q && !rx_ready);
        ovr_d   = done && valid_q && !rx_ready;
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = fe_q;
    assign parity_err  = pe_q;
    assign overrun_err = ovr_q;

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick_16x  input  1  one-clk pulse at 16x baud rate, from the team baud generator.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  received word, LSB first on the wire.
REQ-009 rx_valid  output  1  rx_data and error flags valid; held until accepted.
REQ-010 rx_ready  input  1  consumer accepts when rx_valid && rx_ready.
REQ-011 frame_err  output  1  stop bit sampled low; qualifies rx_valid.
REQ-012 parity_err  output  1  parity mismatch; qualifies rx_valid; always 0 when PARITY_EN=0.
REQ-013 overrun_err  output  1  one-clk pulse when a frame completes while rx_valid is still high.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before use; the FSM uses only the synchronized value.
REQ-015 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; a 4-bit sample counter counts tick_16x pulses only.
REQ-016 IDLE: on a tick with synchronized rx=0 -> START, sample counter cleared to 0.
REQ-017 START: on the tick where the counter reaches 7 (mid-bit), rx=1 -> IDLE (false start, no output); rx=0 -> DATA, counter 0, bit index 0.
REQ-018 DATA: each bit is sampled on the tick where the counter reaches 15, shifted in LSB first; after DATA_BITS samples -> PARITY if PARITY_EN else STOP.
REQ-019 PARITY: sampled on counter 15; parity_err computed as XOR of the data bits, the parity bit and PARITY_ODD being 1.
REQ-020 STOP: sampled on counter 15; rx=1 -> IDLE; rx=0 -> frame_err set for this frame, next state WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until synchronized rx=1, then IDLE; no new start is detected while in WAIT_HIGH (break handling).
REQ-022 On the stop-sample tick, if rx_valid=0 or rx_ready=1 in that cycle, rx_data/frame_err/parity_err SHALL load and rx_valid SHALL be 1 on the next clk.
REQ-023 If rx_valid=1 and rx_ready=0 on the stop-sample tick, the new frame SHALL be dropped, old data and flags kept, and overrun_err pulsed for exactly one clk.
REQ-024 rx_valid SHALL clear on the clk after rx_valid && rx_ready unless a new frame loads in that same cycle (REQ-022 wins).
REQ-025 Ticks arriving without state progress SHALL be ignored; no action occurs on clks without tick_16x except the handshake and synchronizer.

Reset
REQ-026 rst SHALL force state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun_err 0.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no output; after release a frame is received only after a fresh falling edge.

Structure
REQ-028 A shared package uart_pkg SHALL hold the rx state enum and the constants OVERSAMPLE=16 and MID_SAMPLE=7.
REQ-029 The synchronizer SHALL be a sub-module uart_sync2 (2-flop, configurable reset value); everything else stays in uart_rx_oversample.

Verification
REQ-030 Bench: tick_16x every 10 clks; frame 0xA5, 8N1, rx_ready=1 -> rx_valid one clk, rx_data=0xA5, all error flags 0.
REQ-031 Low glitch of 3 tick periods on idle line -> no rx_valid, FSM back in IDLE.
REQ-032 Frame 0x3C with stop bit 0, line held low 20 bit times -> rx_valid with frame_err=1, no second frame until line high plus a new start bit.
REQ-033 PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at the 0x22 stop sample.
REQ-035 rst asserted during data bit 4 of 0xFF, released, then frame 0x5A -> only 0x5A delivered.
